// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one pipeline stage boundary with a valid/ready handshake,
// a two-entry skid buffer (so in_ready comes straight from a flop), a flush
// that squashes everything held, and optional zeroing of empty-stage data.
module pipe_skid_stage #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int ZERO_BUBBLE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [1:0]                count
);

  localparam int BusWidth = CHANNELS * WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  stateT                r_state;
  stateT                w_nextState;
  logic                 r_outValid;
  logic                 r_inReady;
  logic [1:0]           r_count;
  logic [BusWidth-1:0]  r_mainData;
  logic [BusWidth-1:0]  r_skidData;

  logic                 w_accept;
  logic                 w_dequeue;
  logic                 w_nextOutValid;
  logic                 w_nextInReady;
  logic [1:0]           w_nextCount;

  // Handshakes are judged against the registered ready/valid the neighbours see.
  assign w_accept  = in_valid && r_inReady;
  assign w_dequeue = r_outValid && out_ready;

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_mainData;
  assign count     = r_count;

  // Next-state decode; flush overrides every handshake and always empties the stage.
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) w_nextState = ONE;
        ONE: begin
          if (w_accept && !w_dequeue)      w_nextState = TWO;
          else if (!w_accept && w_dequeue) w_nextState = EMPTY;
        end
        TWO:     if (w_dequeue) w_nextState = ONE;
        default: w_nextState = EMPTY;
      endcase
    end
    w_nextOutValid = (w_nextState != EMPTY);
    w_nextInReady  = (w_nextState != TWO);
    w_nextCount    = (w_nextState == TWO) ? 2'd2 :
                     (w_nextState == ONE) ? 2'd1 : 2'd0;
  end

  // State and the handshake/occupancy outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
      r_count    <= 2'd0;
    end else begin
      r_state    <= w_nextState;
      r_outValid <= w_nextOutValid;
      r_inReady  <= w_nextInReady;
      r_count    <= w_nextCount;
    end
  end

  // Data movement: main feeds out_data, skid catches the word that arrives during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mainData <= '0;
      r_skidData <= '0;
    end else if (flush) begin
      if (ZERO_BUBBLE != 0) begin
        r_mainData <= '0;
        r_skidData <= '0;
      end
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) r_mainData <= in_data;
        end
        ONE: begin
          if (w_accept && w_dequeue)       r_mainData <= in_data;
          else if (w_accept && !w_dequeue) r_skidData <= in_data;
          else if (!w_accept && w_dequeue) begin
            if (ZERO_BUBBLE != 0) r_mainData <= '0;
          end
        end
        TWO: begin
          if (w_dequeue) r_mainData <= r_skidData;
        end
        default: begin
          r_mainData <= r_mainData;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised successor to the fixed decode/execute stage registers. One LC-3b pipeline stage boundary with a valid/ready handshake, a two-entry skid buffer so `in_ready` is a flop output, a flush input that squashes in-flight contents, and a bubble-zeroing mode so an empty stage presents all-zero (NOP) data. Instantiated between any two pipeline stages. The packed data bus carries `CHANNELS` lanes of `WIDTH` bits each, for example sr1/sr2/sext/ipacket.

## Interface
- `WIDTH`, 16, bits per lane (lc3b_word width).
- `CHANNELS`, 4, number of lanes; bus width is `CHANNELS*WIDTH`.
- `ZERO_BUBBLE`, 1, when 1 the output data register is cleared whenever the main entry becomes empty; when 0 it holds its last value.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream has data.
- `in_ready`  out  1  stage can accept; registered output.
- `in_data`  in  `CHANNELS*WIDTH`  lane k = bits `[k*WIDTH +: WIDTH]`.
- `flush`  in  1  squash all held entries.
- `out_valid`  out  1  main entry holds data; registered output.
- `out_ready`  in  1  downstream accepts this cycle (deasserted = stall).
- `out_data`  out  `CHANNELS*WIDTH`  main entry contents; registered output.
- `count`  out  2  occupancy: 0, 1 or 2.

## Operation
- Accept: `in_valid && in_ready`. Dequeue: `out_valid && out_ready`.
- Storage: a main register (drives `out_data`) and a skid register, each with a valid bit.
- States:
  - EMPTY: count=0, out_valid=0, in_ready=1.
  - ONE: count=1, out_valid=1, in_ready=1.
  - TWO: count=2, out_valid=1, in_ready=0.
- Transitions when flush=0:
  - EMPTY + accept -> ONE, main<=in_data.
  - ONE + accept + !dequeue -> TWO, skid<=in_data.
  - ONE + accept + dequeue -> ONE, main<=in_data.
  - ONE + !accept + dequeue -> EMPTY.
  - TWO + dequeue -> ONE, main<=skid.
  - Otherwise hold.
- TWO never accepts, because in_ready=0.
- Data ordering is strictly FIFO. No lane reordering, and lanes are passed bit-exact.
- Flush has priority over every other event:
  - Next state is EMPTY and in_ready=1.
  - An accept in the flush cycle is discarded.
  - The skid contents are discarded.
- A dequeue in the flush cycle is not masked. out_valid is not gated combinationally, and the consumer sees the same flush and discards.
- ZERO_BUBBLE=1: main data is set to 0 on every transition into EMPTY (drain, flush, reset). The skid data is also cleared on flush and reset.
- ZERO_BUBBLE=0: the data registers retain their value on drain and flush. Reset still zeroes them.

## Timing
- Reset, evaluated at the clock edge while reset=1:
  - state EMPTY;
  - out_valid=0, in_ready=1, count=0;
  - out_data=0 and skid data=0 for both ZERO_BUBBLE settings.
- Reset overrides flush and all handshakes. Reset mid-operation drops all held data within one edge.
- Latency: an accept at edge N appears on out_data/out_valid after edge N (observable in cycle N+1) when entering from EMPTY, or from ONE with a simultaneous dequeue.
- Throughput: 1 transfer per cycle with out_ready held high.
- Stall: with out_ready low, the stage absorbs at most 2 words, then in_ready drops one cycle after the second accept.
- in_ready rises the cycle after the dequeue that moves skid to main.
- All outputs are flop outputs. There is no combinational path from any input to any output.
- count always equals main_valid + skid_valid.

## Test plan
- **Reset:** assert reset 2 cycles with in_valid=1 and in_data=0xFFFF… -> out_valid=0, in_ready=1, count=0, out_data=0 after release.
- **Streaming:** CHANNELS=4, WIDTH=16, out_ready=1, drive words 0x0001…0x0008 on lane 0 (lanes k = word+k) -> same sequence out, one cycle delay, count=1 steady, no bubbles.
- **Stall/skid:**
  - Hold out_ready=0 and offer 0xA, 0xB, 0xC.
  - Required: 0xA and 0xB are accepted, count=2, in_ready=0, and 0xC is held upstream.
  - Release out_ready: outputs are 0xA, 0xB, 0xC in order, and in_ready returns 1 the cycle after 0xA leaves.
- **Flush in TWO:**
  - Fill with 0x11 and 0x22, then assert flush together with in_valid=1 carrying 0x33.
  - Next cycle: count=0, out_valid=0, out_data=0 (ZERO_BUBBLE=1), and 0x33 is never output.
  - Repeat with ZERO_BUBBLE=0: out_data holds 0x11 and out_valid=0.
- **Simultaneous accept+dequeue in ONE:** main=0x5, offer 0x6 with out_ready=1 -> count stays 1, out_data=0x6 next cycle.
- **Reset mid-stall:** in TWO, assert reset together with flush and out_ready -> EMPTY, in_ready=1, out_data=0 next cycle, and subsequent traffic is normal.
